intc_nsrc_v1: RTL and testbench

//  Parametrised interrupt controller: latches N_SRC peripheral event pulses (TMR/PWM *_if) into pending flags.

---
 rtl/intc_nsrc_v1.sv | 166 ++++++++++++++++
 tb/tb_intc_nsrc_v1.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intc_nsrc_v1.sv
// intc_nsrc_v1 -- parametrised N-source interrupt controller on the SFR bus.
// Latches rising edges of irq_src into pending flags (IF). Pending flags are
// masked by the per-source enables (IE) and the global enable (GIE). The
// lowest-index active source is presented to the CPU as irq_req/irq_id.
// Register map (word steps from BASE_ADDR):
//   +0x0 CTRL (bit0 GIE), +0x4 IE, +0x8 IF (write-1-to-clear),
//   +0xC IRQID (MSB = irq_req, low bits = irq_id), +0x10 SWTRIG (optional).
// Build option: define INTC_SW_TRIG_EN to add the write-only SWTRIG register.
// Writing 1 to SWTRIG bit i sets IF[i]. Without the option that address is
// unmapped.

module intc_nsrc_v1 #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'hFFFFF864,
    parameter int                    N_SRC      = 16,
    parameter int                    ID_WIDTH   = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [ADDR_WIDTH-1:0] sys_addr,
    input  logic                  sys_wr_en,
    input  logic [DATA_WIDTH-1:0] sys_sw_value,
    input  logic [N_SRC-1:0]      irq_src,
    input  logic                  irq_ack,
    output logic [DATA_WIDTH-1:0] sfr_rd_dout,
    output logic                  irq_req,
    output logic [ID_WIDTH-1:0]   irq_id
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_CTRL  = BASE_ADDR;
    localparam logic [ADDR_WIDTH-1:0] ADDR_IE    = BASE_ADDR + ADDR_WIDTH'(4);
    localparam logic [ADDR_WIDTH-1:0] ADDR_IF    = BASE_ADDR + ADDR_WIDTH'(8);
    localparam logic [ADDR_WIDTH-1:0] ADDR_IRQID = BASE_ADDR + ADDR_WIDTH'(12);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    state_t           state;
    logic             gie;
    logic [N_SRC-1:0] ie_q;
    logic [N_SRC-1:0] if_q;
    logic [N_SRC-1:0] src_q;

    logic [N_SRC-1:0]    active;
    logic                any_active;
    logic [ID_WIDTH-1:0] winner;
    logic [N_SRC-1:0]    id_onehot;
    logic                presented_active;
    logic [N_SRC-1:0]    hw_set;
    logic [N_SRC-1:0]    sw_set;
    logic [N_SRC-1:0]    w1c_clr;
    logic [N_SRC-1:0]    ack_clr;
    logic [N_SRC-1:0]    if_next;

    // Address decode for the SFRs of this block
    logic sel_ctrl, sel_ie, sel_if, sel_irqid;
    assign sel_ctrl  = (sys_addr == ADDR_CTRL);
    assign sel_ie    = (sys_addr == ADDR_IE);
    assign sel_if    = (sys_addr == ADDR_IF);
    assign sel_irqid = (sys_addr == ADDR_IRQID);

    // Write data above the widest register is never stored
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^sys_sw_value[DATA_WIDTH-1:N_SRC];

`ifdef INTC_SW_TRIG_EN
    localparam logic [ADDR_WIDTH-1:0] ADDR_SWTRIG = BASE_ADDR + ADDR_WIDTH'(16);
    logic sel_swtrig;
    assign sel_swtrig = (sys_addr == ADDR_SWTRIG);
    assign sw_set     = (sys_wr_en && sel_swtrig) ? sys_sw_value[N_SRC-1:0] : '0;
`else
    assign sw_set     = '0;
`endif

    assign active     = if_q & ie_q & {N_SRC{gie}};
    assign any_active = |active;
    assign hw_set     = irq_src & ~src_q;
    assign w1c_clr    = (sys_wr_en && sel_if) ? sys_sw_value[N_SRC-1:0] : '0;
    assign ack_clr    = (state == REQ && irq_ack) ? id_onehot : '0;
    // Set terms are OR-ed in last, so a same-cycle set beats any clear
    assign if_next    = (if_q & ~(w1c_clr | ack_clr)) | hw_set | sw_set;
    assign presented_active = |(active & id_onehot);

    // Priority pick: scanning downward leaves the lowest active index
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
        winner = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (active[i]) winner = ID_WIDTH'(i);
        end
    end

    // One-hot mask of the presented source, used for ack-clear and withdraw
    always_comb begin
        id_onehot = '0;
        for (int i = 0; i < N_SRC; i++) begin
            id_onehot[i] = (irq_id == ID_WIDTH'(i));
        end
    end

    // Control, enable and pending-flag registers plus the edge-detect history
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
        if (!sys_rst_n) begin
            gie   <= 1'b0;
            ie_q  <= '0;
            if_q  <= '0;
            src_q <= '0;
        end else begin
            src_q <= irq_src;
            if_q  <= if_next;
            if (sys_wr_en && sel_ctrl) gie  <= sys_sw_value[0];
            if (sys_wr_en && sel_ie)   ie_q <= sys_sw_value[N_SRC-1:0];
        end
    end

    // Request FSM: latch the winner, hold it until ack or withdraw
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state   <= IDLE;
            irq_req <= 1'b0;
            irq_id  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_active) begin
                        irq_id  <= winner;
                        irq_req <= 1'b1;
                        state   <= REQ;
                    end
                end
                REQ: begin
                    // Ack and withdraw both drop the request; the flag clear on
                    // ack is handled by ack_clr in the flag path.
                    if (irq_ack || !presented_active) begin
                        irq_req <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    irq_req <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    // Combinational read mux; zero when no SFR of this block is addressed
    always_comb begin
        sfr_rd_dout = '0;
        if (sel_ctrl) begin
            sfr_rd_dout[0] = gie;
        end else if (sel_ie) begin
            sfr_rd_dout[N_SRC-1:0] = ie_q;
        end else if (sel_if) begin
            sfr_rd_dout[N_SRC-1:0] = if_q;
        end else if (sel_irqid) begin
            sfr_rd_dout[DATA_WIDTH-1]  = irq_req;
            sfr_rd_dout[ID_WIDTH-1:0]  = irq_id;
        end
    end

endmodule

// File: tb/tb_intc_nsrc_v1.sv
// Testbench for intc_nsrc_v1: directed scenarios with literal expectations
// plus randomized traffic, all compared every cycle against a behavioural model.
// The optional SWTRIG register is exercised when INTC_SW_TRIG_EN is defined.

module tb_intc_nsrc_v1;

    localparam logic [31:0] BASE = 32'hFFFFF864;
    localparam logic [31:0] OFF_CTRL = 32'h0, OFF_IE = 32'h4, OFF_IF = 32'h8,
                            OFF_IRQID = 32'hC, OFF_SWTRIG = 32'h10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] sys_addr = '0;
    logic        sys_wr_en = 1'b0;
    logic [31:0] sys_sw_value = '0;
    logic [15:0] irq_src = '0;
    logic        irq_ack = 1'b0;
    logic [31:0] sfr_rd_dout;
    logic        irq_req;
    logic [3:0]  irq_id;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    intc_nsrc_v1 dut (
        .sys_clk     (clk),
        .sys_rst_n   (rst_n),
        .sys_addr    (sys_addr),
        .sys_wr_en   (sys_wr_en),
        .sys_sw_value(sys_sw_value),
        .irq_src     (irq_src),
        .irq_ack     (irq_ack),
        .sfr_rd_dout (sfr_rd_dout),
        .irq_req     (irq_req),
        .irq_id      (irq_id)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_cur is the presented source number, or -1 when nothing is presented.
    bit          m_gie;
    logic [15:0] m_ie, m_if, m_prev_src;
    int          m_cur;
    int          m_last_id;

    function automatic int lowest(input logic [15:0] v);
        for (int i = 0; i < 16; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] r;
        r = '0;
        if (a == BASE + OFF_CTRL)       r[0] = m_gie;
        else if (a == BASE + OFF_IE)    r[15:0] = m_ie;
        else if (a == BASE + OFF_IF)    r[15:0] = m_if;
        else if (a == BASE + OFF_IRQID) r = {(m_cur >= 0), 27'b0, 4'(m_last_id)};
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        logic [15:0] enabled_pending, raise, drop;
        if (!rst_n) begin
            m_gie <= 1'b0; m_ie <= '0; m_if <= '0; m_prev_src <= '0;
            m_cur <= -1;   m_last_id <= 0;
        end else begin
            enabled_pending = m_gie ? (m_if & m_ie) : 16'h0;
            raise = irq_src & ~m_prev_src;
`ifdef INTC_SW_TRIG_EN
            if (sys_wr_en && sys_addr == BASE + OFF_SWTRIG) raise = raise | sys_sw_value[15:0];
`endif
            drop = (sys_wr_en && sys_addr == BASE + OFF_IF) ? sys_sw_value[15:0] : 16'h0;
            if (m_cur < 0) begin
                if (enabled_pending != 0) begin
                    m_cur     <= lowest(enabled_pending);
                    m_last_id <= lowest(enabled_pending);
                end
            end else if (irq_ack) begin
                drop[m_cur] = 1'b1;
                m_cur <= -1;
            end else if (!enabled_pending[m_cur]) begin
                m_cur <= -1;
            end
            m_if       <= (m_if & ~drop) | raise;
            m_prev_src <= irq_src;
            if (sys_wr_en && sys_addr == BASE + OFF_CTRL) m_gie <= sys_sw_value[0];
            if (sys_wr_en && sys_addr == BASE + OFF_IE)   m_ie  <= sys_sw_value[15:0];
        end
    end

    // Mid-cycle comparison of every DUT output against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            check("irq_req", 32'(irq_req), 32'(m_cur >= 0));
            check("irq_id", 32'(irq_id), 32'(m_last_id));
            check("rd_dout", sfr_rd_dout, model_read(sys_addr));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] data);
        sys_addr = BASE + off; sys_sw_value = data; sys_wr_en = 1'b1;
        tick();
        sys_wr_en = 1'b0;
    endtask

    task automatic chk_rd(input string name, input logic [31:0] off, input logic [31:0] exp);
        sys_addr = BASE + off;
        #1;
        check(name, sfr_rd_dout, exp);
    endtask

    task automatic pulse(input logic [15:0] bits);
        irq_src = bits;
        tick();
        irq_src = '0;
    endtask

    task automatic ack();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    initial begin
        logic [31:0] ra;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        cmp_en = 1'b1;

        // Reset state
        check("rst_irq_req", 32'(irq_req), 32'd0);
        chk_rd("rst_ctrl", OFF_CTRL, 32'h0);
        chk_rd("rst_ie", OFF_IE, 32'h0);
        chk_rd("rst_if", OFF_IF, 32'h0);
        chk_rd("rst_irqid", OFF_IRQID, 32'h0);

        // Basic path: edge -> IF next cycle -> irq_req the cycle after
        wr(OFF_CTRL, 32'h1);
        wr(OFF_IE, 32'h0004);
        pulse(16'h0004);
        chk_rd("basic_if", OFF_IF, 32'h0004);
        check("basic_req_t1", 32'(irq_req), 32'd0);
        tick();
        check("basic_req", 32'(irq_req), 32'd1);
        check("basic_id", 32'(irq_id), 32'd2);
        chk_rd("basic_irqid", OFF_IRQID, 32'h80000002);
        ack();
        check("basic_ack_req", 32'(irq_req), 32'd0);
        chk_rd("basic_ack_if", OFF_IF, 32'h0);

        // Priority and no pre-emption
        wr(OFF_IE, 32'hFFFF);
        pulse(16'h0220);
        tick();
        check("prio_req", 32'(irq_req), 32'd1);
        check("prio_id5", 32'(irq_id), 32'd5);
        pulse(16'h0002);
        tick();
        check("nopreempt_id", 32'(irq_id), 32'd5);
        ack();
        check("gap_req", 32'(irq_req), 32'd0);
        tick();
        check("next_id1", 32'(irq_id), 32'd1);
        check("next_req1", 32'(irq_req), 32'd1);
        ack();
        check("gap2_req", 32'(irq_req), 32'd0);
        tick();
        check("next_id9", 32'(irq_id), 32'd9);
        ack();
        chk_rd("prio_if_empty", OFF_IF, 32'h0);

        // Masking by GIE, then withdraw via IE
        wr(OFF_CTRL, 32'h0);
        pulse(16'h0008);
        chk_rd("mask_if", OFF_IF, 32'h0008);
        repeat (2) tick();
        check("mask_req", 32'(irq_req), 32'd0);
        wr(OFF_CTRL, 32'h1);
        check("unmask_req_early", 32'(irq_req), 32'd0);
        tick();
        check("unmask_req", 32'(irq_req), 32'd1);
        check("unmask_id", 32'(irq_id), 32'd3);
        wr(OFF_IE, 32'hFFF7);
        tick();
        check("withdraw_req", 32'(irq_req), 32'd0);
        chk_rd("withdraw_if", OFF_IF, 32'h0008);
        wr(OFF_IF, 32'hFFFF);
        wr(OFF_IE, 32'hFFFF);

        // Set beats W1C; a held level is one event
        wr(OFF_CTRL, 32'h0);
        sys_addr = BASE + OFF_IF; sys_sw_value = 32'h10; sys_wr_en = 1'b1;
        irq_src = 16'h0010;
        tick();
        sys_wr_en = 1'b0;
        chk_rd("setwins_if", OFF_IF, 32'h0010);
        wr(OFF_IF, 32'h0010);
        repeat (10) tick();
        chk_rd("level_if", OFF_IF, 32'h0);
        irq_src = '0;
        tick();
        chk_rd("level_drop_if", OFF_IF, 32'h0);
        wr(OFF_CTRL, 32'h1);

        // Software trigger register
        wr(OFF_SWTRIG, 32'h8000);
`ifdef INTC_SW_TRIG_EN
        chk_rd("swtrig_if", OFF_IF, 32'h8000);
        tick();
        check("swtrig_req", 32'(irq_req), 32'd1);
        check("swtrig_id", 32'(irq_id), 32'd15);
        chk_rd("swtrig_rd", OFF_SWTRIG, 32'h0);
        ack();
        tick();
`else
        chk_rd("noswtrig_if", OFF_IF, 32'h0);
        chk_rd("noswtrig_rd", OFF_SWTRIG, 32'h0);
        tick();
        check("noswtrig_req", 32'(irq_req), 32'd0);
`endif

        // Randomized traffic, model compared every cycle
        for (int c = 0; c < 3000; c++) begin
            irq_src = 16'($urandom & $urandom & $urandom);
            irq_ack = ($urandom_range(0, 3) == 0);
            sys_wr_en = 1'b0;
            sys_sw_value = $urandom;
            case ($urandom_range(0, 15))
                0: begin sys_addr = BASE + OFF_CTRL; sys_sw_value = 32'($urandom_range(0, 7) != 0); sys_wr_en = 1'b1; end
                1: begin sys_addr = BASE + OFF_IE; sys_wr_en = 1'b1; end
                2, 3: begin sys_addr = BASE + OFF_IF; sys_sw_value = $urandom & $urandom; sys_wr_en = 1'b1; end
                4: begin sys_addr = BASE + OFF_SWTRIG; sys_sw_value = $urandom & $urandom & $urandom; sys_wr_en = 1'b1; end
                5: begin sys_addr = $urandom; sys_wr_en = 1'b1; end
                default: begin
                    ra = 32'($urandom_range(0, 6)) * 4;
                    sys_addr = (ra == 24) ? $urandom : BASE + ra;
                end
            endcase
            tick();
        end
        irq_src = '0; irq_ack = 1'b0; sys_wr_en = 1'b0;

        // Async reset in the middle of a request
        wr(OFF_CTRL, 32'h0);
        wr(OFF_IF, 32'hFFFF);
        wr(OFF_IE, 32'hFFFF);
        wr(OFF_CTRL, 32'h1);
        tick();
        pulse(16'h0040);
        tick();
        check("prereset_req", 32'(irq_req), 32'd1);
        check("prereset_id", 32'(irq_id), 32'd6);
        #2 rst_n = 1'b0;
        #1;
        check("reset_req", 32'(irq_req), 32'd0);
        check("reset_id", 32'(irq_id), 32'd0);
        chk_rd("reset_ctrl", OFF_CTRL, 32'h0);
        chk_rd("reset_ie", OFF_IE, 32'h0);
        chk_rd("reset_if", OFF_IF, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) tick();
        check("post_reset_req", 32'(irq_req), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
